// File: rtl/piso_shift_tx.sv
// piso_shift_tx
// Parallel-in, serial-out transmitter. A word is accepted over a valid/ready
// handshake and then shifted out one bit per clock. A shift-enable strobe
// accompanies the data so that a receiving shift register on the same clock
// can capture the word.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    asynchronous reset, active low
//   i_data   parallel word to transmit
//   i_valid  i_data / i_right valid this cycle
//   i_right  1 = MSB first, 0 = LSB first (sampled only at accept)
//   o_ready  block can accept a word this cycle
//   o_sd     serial data bit
//   o_sv     shift-enable strobe, o_sd meaningful while high
//   o_busy   word in flight (SHIFT or DONE)
//   o_done   one-cycle pulse after the last bit
//
// state | meaning
// IDLE  | waiting for a word, o_ready high
// SHIFT | driving one bit per cycle for WIDTH cycles, o_sv high
// DONE  | single-cycle completion pulse on o_done

module piso_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_right,
  output logic             o_ready,
  output logic             o_sd,
  output logic             o_sv,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_right;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_right <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_shreg <= i_data;
            r_right <= i_right;
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The outgoing bit always sits at the end selected by r_right;
          // zeros are shifted in behind it.
          if (r_right) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          end else begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
          end
          // Counter holds at zero on the last bit so it never leaves 0..WIDTH-1.
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs decode registered state only.
  logic w_shift;
  assign w_shift = (r_state == S_SHIFT);

  assign o_ready = (r_state == S_IDLE);
  assign o_sv    = w_shift;
  assign o_busy  = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign o_done  = (r_state == S_DONE);
  assign o_sd    = w_shift & (r_right ? r_shreg[WIDTH-1] : r_shreg[0]);

endmodule

// File: tb/tb_piso_shift_tx.sv
module tb_piso_shift_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data = '0;
  logic         valid = 1'b0;
  logic         right = 1'b0;
  logic         ready, sd, sv, busy, done;

  piso_shift_tx #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_data  (data),
    .i_valid (valid),
    .i_right (right),
    .o_ready (ready),
    .o_sd    (sd),
    .o_sv    (sv),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Loopback receiver: bidirectional shift register gated by the strobe.
  logic [W-1:0] rx_q = '0;
  logic         rx_right = 1'b0;
  always @(posedge clk) begin
    if (sv) rx_q <= rx_right ? {rx_q[W-2:0], sd} : {sd, rx_q[W-1:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output vector order: {ready, busy, sv, sd, done}
  function automatic logic [4:0] outs();
    return {ready, busy, sv, sd, done};
  endfunction

  // seq holds the expected serial bits in send order, first bit at seq[W-1].
  task automatic send_word(input logic [W-1:0] d, input logic r,
                           input logic [W-1:0] seq, input string tag);
    @(negedge clk);
    data = d; right = r; valid = 1'b1; rx_right = r;
    @(posedge clk);
    #1;
    // Inputs outside IDLE must be ignored, so disturb them mid-word.
    valid = 1'b0; data = ~d; right = ~r;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk({tag, " shift"}, outs(), {1'b0, 1'b1, 1'b1, seq[W-1-i], 1'b0});
    end
    @(negedge clk);
    chk({tag, " done"}, outs(), 5'b01001);
    chk({tag, " rx_q"}, rx_q, d);
    @(negedge clk);
    chk({tag, " ready"}, outs(), 5'b10000);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         right;
    logic [W-1:0] seq;
  } vec_t;

  typedef struct {
    logic sd;
    logic last;
  } ent_t;

  vec_t vecs[12];
  ent_t mq[$];

  initial begin
    int n_ready;
    int prev;
    logic [4:0] exp_o;

    vecs[0]  = '{4'b1011, 1'b1, 4'b1011};
    vecs[1]  = '{4'b1011, 1'b0, 4'b1101};
    vecs[2]  = '{4'h0,    1'b1, 4'b0000};
    vecs[3]  = '{4'h0,    1'b0, 4'b0000};
    vecs[4]  = '{4'hF,    1'b1, 4'b1111};
    vecs[5]  = '{4'hF,    1'b0, 4'b1111};
    vecs[6]  = '{4'h5,    1'b1, 4'b0101};
    vecs[7]  = '{4'h5,    1'b0, 4'b1010};
    vecs[8]  = '{4'hA,    1'b1, 4'b1010};
    vecs[9]  = '{4'hA,    1'b0, 4'b0101};
    vecs[10] = '{4'h9,    1'b1, 4'b1001};
    vecs[11] = '{4'h9,    1'b0, 4'b1001};

    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = i[0]; data = W'($urandom); right = 1'($urandom);
      #1 chk("reset hold", outs(), 5'b10000);
    end
    @(negedge clk);
    valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("release idle", outs(), 5'b10000);

    // Table-driven words, right/left mode and loopback.
    for (int v = 0; v < 12; v++) begin
      send_word(vecs[v].data, vecs[v].right, vecs[v].seq, $sformatf("vec%0d", v));
    end

    // Reset mid-shift of 4'b1100 in right mode.
    @(negedge clk);
    data = 4'b1100; right = 1'b1; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk); chk("abort bit0", outs(), 5'b01110);
    @(negedge clk); chk("abort bit1", outs(), 5'b01110);
    @(negedge clk); chk("abort bit2", outs(), 5'b01100);
    #2 rst_n = 1'b0;
    #1 chk("abort immediate", outs(), 5'b10000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort held", outs(), 5'b10000);
    end
    rst_n = 1'b1;
    send_word(4'b0110, 1'b1, 4'b0110, "post-reset");

    // Valid held high: accept only on IDLE edges, one per W+2 cycles.
    @(negedge clk);
    valid = 1'b1; right = 1'b0;
    n_ready = 0; prev = -1;
    for (int c = 0; c < 24; c++) begin
      if (ready) begin
        n_ready++;
        if (prev >= 0) chk("hs spacing", c - prev, W + 2);
        prev = c;
      end
      data = W'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    chk("hs accepts", n_ready, 4);

    // Randomized run against a word-level queue model.
    repeat (W + 3) @(negedge clk);
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      if (mq.size() == 0)   exp_o = 5'b10000;
      else if (mq[0].last)  exp_o = 5'b01001;
      else                  exp_o = {1'b0, 1'b1, 1'b1, mq[0].sd, 1'b0};
      chk($sformatf("rand c%0d", c), outs(), exp_o);
      valid = ($urandom_range(0, 3) != 0);
      data  = W'($urandom);
      right = 1'($urandom);
      @(posedge clk);
      if (mq.size() != 0) begin
        void'(mq.pop_front());
      end else if (valid) begin
        for (int i = 0; i < W; i++) begin
          mq.push_back('{right ? data[W-1-i] : data[i], 1'b0});
        end
        mq.push_back('{1'b0, 1'b1});
      end
    end
    @(negedge clk);
    valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
